// File: rtl/smi_pkg.sv
// Shared SMI definitions: FSM/op encodings and the framing sync-bit positions
// that the initiator and the FPGA-side responder must agree on.
package smi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int unsigned SYNC_BYTE0_BIT = 0;
  localparam int unsigned SYNC_BYTE2_BIT = 16;
  localparam int unsigned CNT_W          = 4;
  localparam int unsigned CNT_MAX        = (1 << CNT_W) - 1;

  // A legal tx word carries a set sync bit in byte0 and a clear one in byte2.
  function automatic logic frame_ok(input logic [31:0] word);
    return word[SYNC_BYTE0_BIT] && !word[SYNC_BYTE2_BIT];
  endfunction

endpackage

// File: rtl/smi_phase_timer.sv
// Loadable down-counter timing one SETUP/STROBE/HOLD phase; o_done is high on
// the last cycle of the phase (count reached zero).
module smi_phase_timer
  import smi_pkg::*;
(
  input  logic             i_sys_clk,
  input  logic             i_rst_b,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d; otherwise a latch is inferred.
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (!i_rst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done = (cnt_q == '0);

endmodule

// File: rtl/smi_bus_master.sv
// SMI initiator: frames 32-bit tx words into 4 SWE byte strobes and gathers
// 4 SOE-strobed bytes into an rx word, with round-robin read/write arbitration.
module smi_bus_master
  import smi_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 3,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic        i_sys_clk,
  input  logic        i_rst_b,
  input  logic [31:0] i_tx_word,
  input  logic        i_tx_valid,
  output logic        o_tx_ready,
  output logic [31:0] o_rx_word,
  output logic        o_rx_valid,
  input  logic        i_rd_en,
  input  logic        i_smi_read_req,
  input  logic        i_smi_write_req,
  output logic        o_smi_soe_se,
  output logic        o_smi_swe_srw,
  output logic [7:0]  o_smi_data,
  output logic        o_smi_data_oe,
  input  logic [7:0]  i_smi_data,
  output logic        o_busy,
  output logic        o_frame_err
);

  if (SETUP_CYC < 1 || SETUP_CYC > CNT_MAX ||
      STROBE_CYC < 1 || STROBE_CYC > CNT_MAX ||
      HOLD_CYC < 1 || HOLD_CYC > CNT_MAX) begin : g_bad_timing
    $fatal(1, "smi_bus_master: SETUP_CYC/STROBE_CYC/HOLD_CYC must be 1..15");
  end

  // Timer reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  op_e         last_op_q, last_op_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] tx_sh_q, tx_sh_d;
  logic [31:0] rx_sh_q, rx_sh_d;
  logic [31:0] rx_word_q, rx_word_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  data_q, data_d;
  logic        soe_q, soe_d;
  logic        swe_q, swe_d;
  logic        oe_q, oe_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  logic             tx_ready;
  logic             frame_err;

  logic wr_cand, rd_cand, take_wr, take_rd;

  assign wr_cand = i_tx_valid && i_smi_write_req;
  assign rd_cand = i_rd_en && i_smi_read_req;
  // With both pending, the op not served last time wins.
  assign take_wr = wr_cand && (!rd_cand || last_op_q == OP_READ);
  assign take_rd = rd_cand && !take_wr;

  smi_phase_timer u_timer (
    .i_sys_clk  (i_sys_clk),
    .i_rst_b    (i_rst_b),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .o_done     (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    last_op_d  = last_op_q;
    byte_cnt_d = byte_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_word_d  = rx_word_q;
    rx_valid_d = 1'b0;
    data_d     = data_q;
    tmr_load   = 1'b0;
    tmr_val    = SETUP_LD;
    tx_ready   = 1'b0;
    frame_err  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        byte_cnt_d = 2'd0;
        if (take_wr) begin
          tx_ready  = 1'b1;
          last_op_d = OP_WRITE;
          if (frame_ok(i_tx_word)) begin
            op_d     = OP_WRITE;
            data_d   = i_tx_word[7:0];
            tx_sh_d  = {8'h00, i_tx_word[31:8]};
            state_d  = ST_SETUP;
            tmr_load = 1'b1;
            tmr_val  = SETUP_LD;
          end else begin
            frame_err = 1'b1;
          end
        end else if (take_rd) begin
          last_op_d = OP_READ;
          op_d      = OP_READ;
          state_d   = ST_SETUP;
          tmr_load  = 1'b1;
          tmr_val   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_STROBE;
          tmr_load = 1'b1;
          tmr_val  = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (tmr_done) begin
          // Last low cycle: the responder has had the whole strobe to drive data.
          if (op_q == OP_READ) begin
            rx_sh_d = {i_smi_data, rx_sh_q[31:8]};
          end
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          if (byte_cnt_q != 2'd3) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            state_d    = ST_SETUP;
            tmr_load   = 1'b1;
            tmr_val    = SETUP_LD;
            if (op_q == OP_WRITE) begin
              data_d  = tx_sh_q[7:0];
              tx_sh_d = {8'h00, tx_sh_q[31:8]};
            end
          end else begin
            byte_cnt_d = 2'd0;
            state_d    = ST_IDLE;
            if (op_q == OP_READ) begin
              rx_word_d  = rx_sh_q;
              rx_valid_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pad-side controls are decoded from the next state and registered, so they
    // only move on phase boundaries and never glitch.
    soe_d = !(state_d == ST_STROBE && op_d == OP_READ);
    swe_d = !(state_d == ST_STROBE && op_d == OP_WRITE);
    oe_d  = (state_d != ST_IDLE) && (op_d == OP_WRITE);
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_READ;
      last_op_q  <= OP_READ;
      byte_cnt_q <= 2'd0;
      // NOTE: the shift registers are reset too, so a word cut short by reset cannot leak out later.
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_word_q  <= '0;
      rx_valid_q <= 1'b0;
      data_q     <= '0;
      soe_q      <= 1'b1;
      swe_q      <= 1'b1;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      last_op_q  <= last_op_d;
      byte_cnt_q <= byte_cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_word_q  <= rx_word_d;
      rx_valid_q <= rx_valid_d;
      data_q     <= data_d;
      soe_q      <= soe_d;
      swe_q      <= swe_d;
      oe_q       <= oe_d;
    end
  end

  assign o_tx_ready    = tx_ready;
  assign o_frame_err   = frame_err;
  assign o_rx_word     = rx_word_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_smi_soe_se  = soe_q;
  assign o_smi_swe_srw = swe_q;
  assign o_smi_data    = data_q;
  assign o_smi_data_oe = oe_q;
  assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_smi_bus_master.sv
// Directed bench for smi_bus_master: default-timing instance plus a 1/1/1
// timing instance, a byte responder for reads, and a negedge bus monitor.
module tb_smi_bus_master;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] tx_word = '0;
  logic        tx_valid = 1'b0, rd_en = 1'b0, rd_req = 1'b0, wr_req = 1'b0;
  logic [7:0]  smi_din = 8'h00;
  logic        tx_ready, rx_valid, soe, swe, oe, busy, frame_err;
  logic [31:0] rx_word;
  logic [7:0]  smi_dout;

  logic [31:0] f_tx_word = '0;
  logic        f_tx_valid = 1'b0, f_wr_req = 1'b0;
  logic        f_rd_en = 1'b0, f_rd_req = 1'b0;
  logic [7:0]  f_smi_din = 8'h00;
  logic        f_tx_ready, f_rx_valid, f_soe, f_swe, f_oe, f_busy, f_frame_err;
  logic [31:0] f_rx_word;
  logic [7:0]  f_smi_dout;

  smi_bus_master dut (
    .i_sys_clk(clk), .i_rst_b(rst_b),
    .i_tx_word(tx_word), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_rx_word(rx_word), .o_rx_valid(rx_valid),
    .i_rd_en(rd_en), .i_smi_read_req(rd_req), .i_smi_write_req(wr_req),
    .o_smi_soe_se(soe), .o_smi_swe_srw(swe),
    .o_smi_data(smi_dout), .o_smi_data_oe(oe), .i_smi_data(smi_din),
    .o_busy(busy), .o_frame_err(frame_err)
  );

  smi_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut_f (
    .i_sys_clk(clk), .i_rst_b(rst_b),
    .i_tx_word(f_tx_word), .i_tx_valid(f_tx_valid), .o_tx_ready(f_tx_ready),
    .o_rx_word(f_rx_word), .o_rx_valid(f_rx_valid),
    .i_rd_en(f_rd_en), .i_smi_read_req(f_rd_req), .i_smi_write_req(f_wr_req),
    .o_smi_soe_se(f_soe), .o_smi_swe_srw(f_swe),
    .o_smi_data(f_smi_dout), .o_smi_data_oe(f_oe), .i_smi_data(f_smi_din),
    .o_busy(f_busy), .o_frame_err(f_frame_err)
  );

  // Responder: presents the next table byte on each falling SOE.
  logic [7:0] rd_tab [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  int rd_idx = 0;
  always @(negedge soe) begin
    if (rst_b) begin
      smi_din = rd_tab[rd_idx % 4];
      rd_idx  = rd_idx + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor for the default instance, sampled mid-cycle.
  int swe_falls = 0, soe_falls = 0, overlap = 0, oe_bad = 0;
  int rx_cnt = 0, rdy_cnt = 0, ferr_cnt = 0, oe_cyc = 0, busy_cyc = 0;
  int swe_run = 0, soe_run = 0;
  logic [31:0] last_rx = '0;
  logic prev_swe = 1'b1, prev_soe = 1'b1, prev_busy = 1'b0;
  logic [7:0] wr_bytes [$];
  int swe_lens [$];
  int soe_lens [$];
  int ops [$];  // 1 = write, 0 = read

  always @(negedge clk) begin
    if (!rst_b) begin
      prev_swe <= 1'b1; prev_soe <= 1'b1; prev_busy <= 1'b0;
      swe_run <= 0; soe_run <= 0;
    end else begin
      if (!swe && !soe) overlap <= overlap + 1;
      if (prev_swe && !swe) begin
        swe_falls <= swe_falls + 1;
        wr_bytes.push_back(smi_dout);
        if (!oe) oe_bad <= oe_bad + 1;
      end
      if (prev_soe && !soe) soe_falls <= soe_falls + 1;
      if (!swe) swe_run <= swe_run + 1;
      else if (!prev_swe) begin swe_lens.push_back(swe_run); swe_run <= 0; end
      if (!soe) soe_run <= soe_run + 1;
      else if (!prev_soe) begin soe_lens.push_back(soe_run); soe_run <= 0; end
      if (busy && !prev_busy) ops.push_back(oe ? 1 : 0);
      if (oe) oe_cyc <= oe_cyc + 1;
      if (busy) busy_cyc <= busy_cyc + 1;
      if (rx_valid) begin rx_cnt <= rx_cnt + 1; last_rx <= rx_word; end
      if (tx_ready) rdy_cnt <= rdy_cnt + 1;
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      prev_swe <= swe; prev_soe <= soe; prev_busy <= busy;
    end
  end

  // Monitor for the fast-timing instance.
  int f_falls = 0, f_run = 0, f_busy_cyc = 0;
  logic f_prev_swe = 1'b1;
  logic [7:0] f_bytes [$];
  int f_lens [$];
  int f_rdy_cyc [$];

  always @(negedge clk) begin
    if (!rst_b) begin
      f_prev_swe <= 1'b1; f_run <= 0;
    end else begin
      if (f_prev_swe && !f_swe) begin
        f_falls <= f_falls + 1;
        f_bytes.push_back(f_smi_dout);
      end
      if (!f_swe) f_run <= f_run + 1;
      else if (!f_prev_swe) begin f_lens.push_back(f_run); f_run <= 0; end
      if (f_busy) f_busy_cyc <= f_busy_cyc + 1;
      if (f_tx_ready) f_rdy_cyc.push_back(cyc);
      f_prev_swe <= f_swe;
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the default instance to go idle, then one more cycle so the
  // monitor has seen the trailing IDLE cycle.
  task automatic wait_idle(input string tag);
    int n = 0;
    tick();
    while (busy && n < 200) begin tick(); n++; end
    if (n >= 200) check({tag, "_idle_timeout"}, busy, 0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int s_falls, s_bytes, s_lens, s_oe, s_busy, s_soe, s_soel, s_rx, s_rdy;
    int s_ferr, s_ops, s_ovl, s_f, s_fb, s_fl, s_fr, s_fbusy, n;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_soe", soe, 1);
    check("rst_swe", swe, 1);
    check("rst_data", smi_dout, 0);
    check("rst_oe", oe, 0);
    check("rst_rx_word", rx_word, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    rst_b = 1'b1;
    tick();

    // Illegal framing: byte2 sync bit set
    s_falls = swe_falls; s_ferr = ferr_cnt;
    tx_word = 32'h4433_2211; tx_valid = 1'b1; wr_req = 1'b1;
    #1;
    check("ferr_ready", tx_ready, 1);
    check("ferr_pulse", frame_err, 1);
    tick();
    tx_valid = 1'b0;
    repeat (6) tick();
    check("ferr_busy", busy, 0);
    check("ferr_no_swe", swe_falls - s_falls, 0);
    check("ferr_count", ferr_cnt - s_ferr, 1);

    // Legal write, default timing
    s_falls = swe_falls; s_bytes = wr_bytes.size(); s_lens = swe_lens.size();
    s_oe = oe_cyc; s_busy = busy_cyc; s_soe = soe_falls;
    w = 32'h4432_2211;
    tx_word = w; tx_valid = 1'b1;
    #1;
    check("wr_ready", tx_ready, 1);
    check("wr_no_ferr", frame_err, 0);
    tick();
    tx_valid = 1'b0;
    wait_idle("wr");
    check("wr_swe_falls", swe_falls - s_falls, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr_byte%0d", i), wr_bytes[s_bytes + i], w[8*i +: 8]);
      check($sformatf("wr_swe_len%0d", i), swe_lens[s_lens + i], 3);
    end
    check("wr_oe_cycles", oe_cyc - s_oe, 28);
    check("wr_busy_cycles", busy_cyc - s_busy, 28);
    check("wr_oe_at_strobe", oe_bad, 0);
    check("wr_no_soe", soe_falls - s_soe, 0);
    wr_req = 1'b0;

    // Read; request drops right after the word starts
    s_rx = rx_cnt; s_soe = soe_falls; s_falls = swe_falls; s_soel = soe_lens.size();
    rd_en = 1'b1; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    wait_idle("rd");
    check("rd_valid_count", rx_cnt - s_rx, 1);
    check("rd_word", last_rx, 32'hD4C3_B2A1);
    check("rd_word_out", rx_word, 32'hD4C3_B2A1);
    check("rd_soe_falls", soe_falls - s_soe, 4);
    check("rd_soe_len", soe_lens[s_soel], 3);
    check("rd_no_swe", swe_falls - s_falls, 0);
    rd_en = 1'b0;

    // Both pending continuously after reset: W, R, W, R
    rst_b = 1'b0;
    tick(); tick();
    rst_b = 1'b1;
    tick();
    s_ops = ops.size(); s_ovl = overlap; s_rdy = rdy_cnt; s_rx = rx_cnt;
    tx_word = w; tx_valid = 1'b1; wr_req = 1'b1; rd_en = 1'b1; rd_req = 1'b1;
    n = 0;
    while (ops.size() - s_ops < 4 && n < 300) begin tick(); n++; end
    tx_valid = 1'b0; wr_req = 1'b0; rd_en = 1'b0; rd_req = 1'b0;
    check("rr_word_count", ops.size() - s_ops, 4);
    wait_idle("rr");
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_op%0d", i), ops[s_ops + i], (i % 2 == 0) ? 1 : 0);
    check("rr_no_overlap", overlap - s_ovl, 0);
    check("rr_tx_accepts", rdy_cnt - s_rdy, 2);
    check("rr_rx_words", rx_cnt - s_rx, 2);
    check("rr_rx_data", last_rx, 32'hD4C3_B2A1);

    // write_req drops after byte 1; word still completes, next write waits
    s_falls = swe_falls; s_rdy = rdy_cnt;
    tx_word = w; tx_valid = 1'b1; wr_req = 1'b1;
    n = 0;
    while (swe_falls - s_falls < 2 && n < 100) begin tick(); n++; end
    wr_req = 1'b0;
    wait_idle("wdrop");
    check("wdrop_falls", swe_falls - s_falls, 4);
    repeat (10) tick();
    check("wdrop_wait_busy", busy, 0);
    check("wdrop_wait_accepts", rdy_cnt - s_rdy, 1);
    wr_req = 1'b1;
    n = 0;
    while (rdy_cnt - s_rdy < 2 && n < 10) begin tick(); n++; end
    tx_valid = 1'b0;
    check("wdrop_resume_accept", rdy_cnt - s_rdy, 2);
    wait_idle("wdrop2");
    check("wdrop_resume_falls", swe_falls - s_falls, 8);

    // Async reset during the STROBE of byte 2
    s_falls = swe_falls; s_bytes = wr_bytes.size(); s_rx = rx_cnt; s_rdy = rdy_cnt;
    tx_word = w; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    n = 0;
    while (swe_falls - s_falls < 3 && n < 100) begin tick(); n++; end
    check("arst_pre_swe_low", swe, 0);
    #2;
    rst_b = 1'b0;
    #1;
    check("arst_swe", swe, 1);
    check("arst_soe", soe, 1);
    check("arst_oe", oe, 0);
    check("arst_busy", busy, 0);
    tick(); tick();
    rst_b = 1'b1;
    repeat (30) tick();
    check("arst_no_rx", rx_cnt - s_rx, 0);
    check("arst_no_ready", rdy_cnt - s_rdy, 1);
    check("arst_falls", swe_falls - s_falls, 3);
    w = 32'h8876_6655;
    tx_word = w; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    wait_idle("arst_next");
    check("arst_next_falls", swe_falls - s_falls, 7);
    for (int i = 0; i < 4; i++)
      check($sformatf("arst_next_byte%0d", i), wr_bytes[s_bytes + 3 + i], w[8*i +: 8]);
    wr_req = 1'b0;

    // Fast timing instance: two back-to-back words
    s_f = f_falls; s_fb = f_bytes.size(); s_fl = f_lens.size();
    s_fr = f_rdy_cyc.size(); s_fbusy = f_busy_cyc;
    w = 32'h0D0A_0B01;
    f_tx_word = w; f_tx_valid = 1'b1; f_wr_req = 1'b1;
    n = 0;
    while (f_rdy_cyc.size() - s_fr < 2 && n < 60) begin tick(); n++; end
    f_tx_valid = 1'b0;
    check("fast_accepts", f_rdy_cyc.size() - s_fr, 2);
    n = 0;
    tick();
    while (f_busy && n < 60) begin tick(); n++; end
    tick();
    check("fast_idle", f_busy, 0);
    check("fast_word_period", f_rdy_cyc[s_fr + 1] - f_rdy_cyc[s_fr], 13);
    check("fast_falls", f_falls - s_f, 8);
    check("fast_busy_cycles", f_busy_cyc - s_fbusy, 24);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fast_byte%0d", i), f_bytes[s_fb + i], w[8*(i % 4) +: 8]);
      check($sformatf("fast_len%0d", i), f_lens[s_fl + i], 1);
    end
    f_wr_req = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
